// File: rtl/versat_merge_pkg.sv
// versat_merge_pkg: definitions shared by the Versat round-robin merge.
//   arb_state_e   per-channel arbiter state (IDLE / BUSY)
//   STAT_W        width of the optional statistics counters
//   sel_width()   index width for a given requester count
// Optional feature macro used by the merge top: VERSAT_MERGE_STATS_EN.
package versat_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int STAT_W = 32;

  // Index width for N requesters; SEL_W = $clog2(N_SLAVES) in every user.
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/versat_rr_arbiter.sv
// versat_rr_arbiter: one round-robin channel arbiter (IDLE/BUSY).
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester eligible request vector
//   release_grant   end-of-transfer handshake of the granted requester
//   grant_idx       index of the latched winner (held while busy)
//   grant_valid     one-cycle strobe when a new winner is latched
//   busy            channel is in BUSY
//   bubble          channel is in the idle cycle right after a release
module versat_rr_arbiter
  import versat_merge_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int SEL_W    = sel_width(N_SLAVES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SLAVES-1:0] req,
  input  logic                release_grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                busy,
  output logic                bubble
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic             bubble_q, bubble_d;

  logic             found;
  logic [SEL_W-1:0] winner;

  // First requester after the pointer, searching upward with an explicit
  // wrap so that non-power-of-two requester counts work.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = ptr_q;
    for (int k = 1; k <= N_SLAVES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_SLAVES) idx = idx - N_SLAVES;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    bubble_d    = 1'b0;
    grant_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BUSY;
          ptr_d       = winner;
          grant_d     = winner;
          grant_valid = 1'b1;
        end
      end
      BUSY: begin
        // Grant is held until the transfer's last beat handshakes, whatever
        // the requester does with its valid or strobe meanwhile.
        if (release_grant) begin
          state_d  = IDLE;
          bubble_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= SEL_W'(N_SLAVES - 1);
      grant_q  <= '0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      bubble_q <= bubble_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);
  assign bubble    = bubble_q;

endmodule

// File: rtl/versat_rr_merge.sv
// versat_rr_merge: shares one write and one read channel of the Versat
// simple-AXI memory path among N_SLAVES databus requesters, round-robin.
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_last   per-slave request valid, beat accepted, last beat
//   s_addr/s_wdata/s_wstrb/s_len  per-slave request fields (flattened)
//   s_rdata                  read data broadcast to every slave
//   m_w*                     write channel to the bridge
//   m_r*                     read channel to the bridge
// A slave with nonzero strobe is a write requester, otherwise a reader.
// Optional macro VERSAT_MERGE_STATS_EN adds saturating counters
// stat_wgrants, stat_rgrants and stat_wait.
module versat_rr_merge
  import versat_merge_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SLAVES-1:0]          s_valid,
  output logic [N_SLAVES-1:0]          s_ready,
  output logic [N_SLAVES-1:0]          s_last,
  input  logic [ADDR_W*N_SLAVES-1:0]   s_addr,
  input  logic [DATA_W*N_SLAVES-1:0]   s_wdata,
  input  logic [(DATA_W/8)*N_SLAVES-1:0] s_wstrb,
  input  logic [LEN_W*N_SLAVES-1:0]    s_len,
  output logic [DATA_W-1:0]            s_rdata,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic                         m_wlast,
  output logic [ADDR_W-1:0]            m_waddr,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic [LEN_W-1:0]             m_wlen,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  input  logic                         m_rlast,
  output logic [ADDR_W-1:0]            m_raddr,
  output logic [LEN_W-1:0]             m_rlen,
  input  logic [DATA_W-1:0]            m_rdata
`ifdef VERSAT_MERGE_STATS_EN
  ,
  output logic [STAT_W-1:0]            stat_wgrants,
  output logic [STAT_W-1:0]            stat_rgrants,
  output logic [STAT_W-1:0]            stat_wait
`endif
);

  localparam int SEL_W  = sel_width(N_SLAVES);
  localparam int STRB_W = DATA_W / 8;

  logic [N_SLAVES-1:0] w_req, r_req;
  logic [SEL_W-1:0]    w_gnt, r_gnt;
  logic                w_gv, r_gv, w_busy, r_busy, w_bub, r_bub;
  logic                w_rel, r_rel;

  // Classification plus cross-channel exclusion: a slave owned by one
  // channel cannot be picked by the other until that grant is released.
  always_comb begin
    w_req = '0;
    r_req = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_req[i] = s_valid[i] && (|s_wstrb[i*STRB_W +: STRB_W])
                 && !(r_busy && (int'(r_gnt) == i));
      r_req[i] = s_valid[i] && !(|s_wstrb[i*STRB_W +: STRB_W])
                 && !(w_busy && (int'(w_gnt) == i));
    end
  end

  versat_rr_arbiter #(.N_SLAVES(N_SLAVES), .SEL_W(SEL_W)) u_warb (
    .clk(clk), .rst(rst), .req(w_req), .release_grant(w_rel),
    .grant_idx(w_gnt), .grant_valid(w_gv), .busy(w_busy), .bubble(w_bub)
  );

  versat_rr_arbiter #(.N_SLAVES(N_SLAVES), .SEL_W(SEL_W)) u_rarb (
    .clk(clk), .rst(rst), .req(r_req), .release_grant(r_rel),
    .grant_idx(r_gnt), .grant_valid(r_gv), .busy(r_busy), .bubble(r_bub)
  );

  // Channel routing: fields follow the granted slave only while BUSY.
  always_comb begin
    m_wvalid = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlen   = '0;
    m_rvalid = 1'b0;
    m_raddr  = '0;
    m_rlen   = '0;
    if (w_busy) begin
      m_wvalid = s_valid[w_gnt];
      m_waddr  = s_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
      m_wdata  = s_wdata[int'(w_gnt)*DATA_W +: DATA_W];
      m_wstrb  = s_wstrb[int'(w_gnt)*STRB_W +: STRB_W];
      m_wlen   = s_len[int'(w_gnt)*LEN_W +: LEN_W];
    end
    if (r_busy) begin
      m_rvalid = s_valid[r_gnt];
      m_raddr  = s_addr[int'(r_gnt)*ADDR_W +: ADDR_W];
      m_rlen   = s_len[int'(r_gnt)*LEN_W +: LEN_W];
    end
  end

  assign w_rel   = w_busy && m_wvalid && m_wready && m_wlast;
  assign r_rel   = r_busy && m_rvalid && m_rready && m_rlast;
  assign s_rdata = m_rdata;

  always_comb begin
    s_ready = '0;
    s_last  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_ready[i] = (w_busy && (int'(w_gnt) == i) && m_wready)
                || (r_busy && (int'(r_gnt) == i) && m_rready);
      s_last[i]  = (w_busy && (int'(w_gnt) == i) && m_wlast)
                || (r_busy && (int'(r_gnt) == i) && m_rlast);
    end
  end

`ifdef VERSAT_MERGE_STATS_EN
  logic [STAT_W-1:0] wgrants_q, wgrants_d;
  logic [STAT_W-1:0] rgrants_q, rgrants_d;
  logic [STAT_W-1:0] wait_q, wait_d;
  logic              wait_cyc;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  // A pending request stalls when its channel is owned or in its bubble.
  assign wait_cyc = ((|w_req) && (w_busy || w_bub))
                 || ((|r_req) && (r_busy || r_bub));

  always_comb begin
    wgrants_d = sat_inc(wgrants_q, w_gv);
    rgrants_d = sat_inc(rgrants_q, r_gv);
    wait_d    = sat_inc(wait_q, wait_cyc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wgrants_q <= '0;
      rgrants_q <= '0;
      wait_q    <= '0;
    end else begin
      wgrants_q <= wgrants_d;
      rgrants_q <= rgrants_d;
      wait_q    <= wait_d;
    end
  end

  assign stat_wgrants = wgrants_q;
  assign stat_rgrants = rgrants_q;
  assign stat_wait    = wait_q;
`else
  // Grant strobes and bubble flags only feed the statistics block.
  logic stats_unused;
  assign stats_unused = w_gv ^ r_gv ^ w_bub ^ r_bub;
`endif

endmodule

// File: tb/tb_versat_rr_merge.sv
module tb_versat_rr_merge;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready, s_last;
  logic [AW*N-1:0] s_addr;
  logic [DW*N-1:0] s_wdata;
  logic [SW*N-1:0] s_wstrb;
  logic [LW*N-1:0] s_len;
  logic [DW-1:0]   s_rdata;
  logic            m_wvalid, m_wready, m_wlast;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic [LW-1:0]   m_wlen;
  logic            m_rvalid, m_rready, m_rlast;
  logic [AW-1:0]   m_raddr;
  logic [LW-1:0]   m_rlen;
  logic [DW-1:0]   m_rdata;
`ifdef VERSAT_MERGE_STATS_EN
  logic [31:0]     stat_wgrants, stat_rgrants, stat_wait;
`endif

  int total = 0;
  int bad   = 0;

  versat_rr_merge #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_len(s_len),
    .s_rdata(s_rdata),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlen(m_wlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_raddr(m_raddr), .m_rlen(m_rlen), .m_rdata(m_rdata)
`ifdef VERSAT_MERGE_STATS_EN
    , .stat_wgrants(stat_wgrants), .stat_rgrants(stat_rgrants),
    .stat_wait(stat_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [SW-1:0] st, input logic [LW-1:0] l,
                           input logic [DW-1:0] d);
    s_valid[i]            = v;
    s_addr[i*AW +: AW]    = a;
    s_wstrb[i*SW +: SW]   = st;
    s_len[i*LW +: LW]     = l;
    s_wdata[i*DW +: DW]   = d;
  endtask

  initial begin
    logic [N-1:0] onehot;
    rst = 1'b1;
    s_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0; s_len = '0;
    m_wready = 1'b0; m_wlast = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
    m_rdata = 32'hCAFE_0001;
    tick();
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_sready", 64'(s_ready), 64'd0);
    chk("rst_slast", 64'(s_last), 64'd0);
    chk("rst_raddr", 64'(m_raddr), 64'd0);
    chk("rdata_bcast", 64'(s_rdata), 64'hCAFE_0001);
`ifdef VERSAT_MERGE_STATS_EN
    chk("rst_stat_w", 64'(stat_wgrants), 64'd0);
    chk("rst_stat_wait", 64'(stat_wait), 64'd0);
`endif
    rst = 1'b0;

    // Single read from slave 1, four beats.
    set_slave(1, 1'b1, 32'h100, '0, 8'd16, '0);
    m_rready = 1'b1;
    #1;
    chk("rd_idle_latency", 64'(m_rvalid), 64'd0);
    tick();
    chk("rd_rvalid", 64'(m_rvalid), 64'd1);
    chk("rd_raddr", 64'(m_raddr), 64'h100);
    chk("rd_rlen", 64'(m_rlen), 64'd16);
    chk("rd_sready_b1", 64'(s_ready), 64'b0010);
    chk("rd_slast_b1", 64'(s_last), 64'b0000);
    tick();
    tick();
    tick();
    m_rlast = 1'b1;
    #1;
    chk("rd_sready_b4", 64'(s_ready), 64'b0010);
    chk("rd_slast_b4", 64'(s_last), 64'b0010);
    tick();
    chk("rd_bubble", 64'(m_rvalid), 64'd0);
    chk("rd_bubble_sready", 64'(s_ready), 64'd0);
    s_valid = '0;
    m_rlast = 1'b0;
    tick();
    chk("rd_stay_idle", 64'(m_rvalid), 64'd0);

    // Fresh reset, then continuous one-beat reads from all slaves.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      set_slave(i, 1'b1, 32'h1000 * (i + 1), '0, 8'd4, '0);
    m_rready = 1'b1;
    m_rlast  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      onehot = '0;
      onehot[k % N] = 1'b1;
      chk($sformatf("rr_addr_%0d", k), 64'(m_raddr), 64'(32'h1000 * ((k % N) + 1)));
      chk($sformatf("rr_sready_%0d", k), 64'(s_ready), 64'(onehot));
      tick();
      chk($sformatf("rr_idle_%0d", k), 64'(m_rvalid), 64'd0);
    end
    s_valid = '0;
    m_rlast = 1'b0;
    tick();

    // Concurrent: slave 0 writes, slave 2 reads.
    set_slave(0, 1'b1, 32'h200, 4'hF, 8'd8, 32'hAAAA_5555);
    set_slave(2, 1'b1, 32'h300, '0, 8'd8, '0);
    m_wready = 1'b1;
    m_rready = 1'b1;
    tick();
    chk("cc_wvalid", 64'(m_wvalid), 64'd1);
    chk("cc_rvalid", 64'(m_rvalid), 64'd1);
    chk("cc_waddr", 64'(m_waddr), 64'h200);
    chk("cc_wdata", 64'(m_wdata), 64'hAAAA_5555);
    chk("cc_wstrb", 64'(m_wstrb), 64'hF);
    chk("cc_wlen", 64'(m_wlen), 64'd8);
    chk("cc_raddr", 64'(m_raddr), 64'h300);
    chk("cc_sready", 64'(s_ready), 64'b0101);
    tick();
    m_wlast = 1'b1;
    m_rlast = 1'b1;
    #1;
    chk("cc_slast", 64'(s_last), 64'b0101);
    tick();
    s_valid = '0;
    m_wlast = 1'b0;
    m_rlast = 1'b0;
    #1;
    chk("cc_idle_w", 64'(m_wvalid), 64'd0);
    chk("cc_idle_r", 64'(m_rvalid), 64'd0);
    tick();

    // Same slave switches from write to read mid-burst, with backpressure.
    set_slave(0, 1'b1, 32'h400, 4'hF, 8'd12, 32'h1234_5678);
    m_wready = 1'b1;
    tick();
    chk("cf_wvalid", 64'(m_wvalid), 64'd1);
    chk("cf_waddr", 64'(m_waddr), 64'h400);
    chk("cf_sready_b1", 64'(s_ready), 64'b0001);
    tick();
    s_wstrb[3:0] = 4'h0;
    m_wready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_wvalid_%0d", c), 64'(m_wvalid), 64'd1);
      chk($sformatf("bp_sready_%0d", c), 64'(s_ready), 64'd0);
      chk($sformatf("bp_waddr_%0d", c), 64'(m_waddr), 64'h400);
      chk($sformatf("bp_rvalid_%0d", c), 64'(m_rvalid), 64'd0);
      tick();
    end
    chk("cf_wstrb_follow", 64'(m_wstrb), 64'h0);
    m_wready = 1'b1;
    m_wlast  = 1'b1;
    #1;
    chk("cf_last_sready", 64'(s_ready), 64'b0001);
    chk("cf_last_slast", 64'(s_last), 64'b0001);
    tick();
    m_wlast = 1'b0;
    m_wready = 1'b0;
    #1;
    chk("cf_w_released", 64'(m_wvalid), 64'd0);
    chk("cf_r_not_yet", 64'(m_rvalid), 64'd0);
    tick();
    chk("cf_r_grant", 64'(m_rvalid), 64'd1);
    chk("cf_r_addr", 64'(m_raddr), 64'h400);
    chk("cf_w_idle", 64'(m_wvalid), 64'd0);

    // Reset during the second beat of the read.
    m_rready = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rvalid", 64'(m_rvalid), 64'd0);
    chk("mr_raddr", 64'(m_raddr), 64'd0);
    chk("mr_sready", 64'(s_ready), 64'd0);
`ifdef VERSAT_MERGE_STATS_EN
    chk("mr_stat_r", 64'(stat_rgrants), 64'd0);
    chk("mr_stat_w", 64'(stat_wgrants), 64'd0);
    chk("mr_stat_wait", 64'(stat_wait), 64'd0);
`endif
    set_slave(1, 1'b1, 32'h500, '0, 8'd4, '0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_first_addr", 64'(m_raddr), 64'h400);
    chk("mr_first_sready", 64'(s_ready), 64'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
